// File: rtl/ace_snoop_initiator_pkg.sv
// Shared ACE snoop definitions: AC_SNOOP opcodes, CR_RESP bit positions and
// the snoop initiator FSM state encoding.
package ace_pkg;

  localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;

  localparam int CR_DATA_TRANSFER = 0;
  localparam int CR_ERROR         = 1;
  localparam int CR_PASS_DIRTY    = 2;
  localparam int CR_IS_SHARED     = 3;
  localparam int CR_WAS_UNIQUE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AC_SEND,
    ST_RESP,
    ST_DONE
  } snoop_state_e;

endpackage

// File: rtl/ace_snoop_initiator_if.sv
// Home-agent request/completion plus ACE AC/CR/CD channels of the snoop master.
// master = snoop initiator side, slave = home agent + cache side.
interface ace_snoop_initiator_if #(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_BEATS = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic [WIDTH_A-1:0]            req_addr;
  logic [3:0]                    req_snoop;
  logic [2:0]                    req_prot;
  logic                          AC_VALID;
  logic                          AC_READY;
  logic [WIDTH_A-1:0]            AC_ADDR;
  logic [3:0]                    AC_SNOOP;
  logic [2:0]                    AC_PROT;
  logic                          CR_VALID;
  logic                          CR_READY;
  logic [4:0]                    CR_RESP;
  logic                          CD_VALID;
  logic                          CD_READY;
  logic [WIDTH_D-1:0]            CD_DATA;
  logic                          CD_LAST;
  logic                          done_valid;
  logic                          done_ready;
  logic [4:0]                    done_resp;
  logic [WIDTH_D*LINE_BEATS-1:0] done_data;
  logic                          done_data_valid;
  logic                          done_err;

  modport master (
    input  req_valid, req_addr, req_snoop, req_prot, AC_READY,
           CR_VALID, CR_RESP, CD_VALID, CD_DATA, CD_LAST, done_ready,
    output req_ready, AC_VALID, AC_ADDR, AC_SNOOP, AC_PROT, CR_READY,
           CD_READY, done_valid, done_resp, done_data, done_data_valid, done_err
  );

  modport slave (
    output req_valid, req_addr, req_snoop, req_prot, AC_READY,
           CR_VALID, CR_RESP, CD_VALID, CD_DATA, CD_LAST, done_ready,
    input  req_ready, AC_VALID, AC_ADDR, AC_SNOOP, AC_PROT, CR_READY,
           CD_READY, done_valid, done_resp, done_data, done_data_valid, done_err
  );
endinterface

// File: rtl/ace_snoop_initiator_cd_line_collector.sv
// Assembles CD beats into one cache line and flags LAST protocol violations.
// Beat counter saturates at the final slot; overflow beats are drained, not stored.
module ace_cd_line_collector #(
  parameter int WIDTH_D    = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          beat_fire,
  input  logic [WIDTH_D-1:0]            cd_data,
  input  logic                          cd_last,
  output logic                          cd_done,
  output logic                          any_beat,
  output logic                          err,
  output logic [WIDTH_D*LINE_BEATS-1:0] line
);
  localparam int CW = $clog2(LINE_BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(LINE_BEATS - 1);

  logic [CW-1:0]                 beat_cnt_q, beat_cnt_d;
  logic                          full_q, full_d;
  logic                          cd_done_q, cd_done_d;
  logic                          any_beat_q, any_beat_d;
  logic                          err_q, err_d;
  logic [WIDTH_D*LINE_BEATS-1:0] line_q, line_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    full_d     = full_q;
    cd_done_d  = cd_done_q;
    any_beat_d = any_beat_q;
    err_d      = err_q;
    line_d     = line_q;
    if (clear) begin
      beat_cnt_d = '0;
      full_d     = 1'b0;
      cd_done_d  = 1'b0;
      any_beat_d = 1'b0;
      err_d      = 1'b0;
      line_d     = '0;
    end else if (beat_fire) begin
      any_beat_d = 1'b1;
      if (!full_q) line_d[int'(beat_cnt_q)*WIDTH_D +: WIDTH_D] = cd_data;
      if (cd_last) begin
        cd_done_d = 1'b1;
        if (!full_q && beat_cnt_q != LAST_IDX) err_d = 1'b1;
      end else if (!full_q) begin
        // Last slot filled without LAST: stop storing, keep draining until LAST.
        if (beat_cnt_q == LAST_IDX) begin
          full_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      full_q     <= 1'b0;
      cd_done_q  <= 1'b0;
      any_beat_q <= 1'b0;
      err_q      <= 1'b0;
      line_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      full_q     <= full_d;
      cd_done_q  <= cd_done_d;
      any_beat_q <= any_beat_d;
      err_q      <= err_d;
      line_q     <= line_d;
    end
  end

  assign cd_done  = cd_done_q;
  assign any_beat = any_beat_q;
  assign err      = err_q;
  assign line     = line_q;
endmodule

// File: rtl/ace_snoop_initiator.sv
// ACE snoop master: issues one AC snoop, gathers CR and the optional CD line,
// then presents a single completion record until the home agent accepts it.
module ace_snoop_initiator
  import ace_pkg::*;
#(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_BEATS = 4
) (
  input logic                   clk,
  input logic                   rst,
  ace_snoop_initiator_if.master bus
);
  snoop_state_e       state_q, state_d;
  logic [WIDTH_A-1:0] ac_addr_q, ac_addr_d;
  logic [3:0]         ac_snoop_q, ac_snoop_d;
  logic [2:0]         ac_prot_q, ac_prot_d;
  logic [4:0]         resp_q, resp_d;
  logic               cr_got_q, cr_got_d;

  logic cr_ready, cd_ready, cr_fire, cd_fire, clear, resp_exit, err;
  logic cd_done, any_beat, coll_err;
  logic [WIDTH_D*LINE_BEATS-1:0] line;

  assign cr_ready = (state_q == ST_RESP) && !cr_got_q;
  assign cd_ready = (state_q == ST_RESP) && !cd_done;
  assign cr_fire  = bus.CR_VALID && cr_ready;
  assign cd_fire  = bus.CD_VALID && cd_ready;

  // Data beats without DataTransfer must be drained to LAST before completing.
  assign resp_exit = cr_got_q && (cd_done || (!resp_q[CR_DATA_TRANSFER] && !any_beat));
  assign err       = coll_err || (cr_got_q && !resp_q[CR_DATA_TRANSFER] && any_beat);

  always_comb begin
    state_d    = state_q;
    ac_addr_d  = ac_addr_q;
    ac_snoop_d = ac_snoop_q;
    ac_prot_d  = ac_prot_q;
    resp_d     = resp_q;
    cr_got_d   = cr_got_q;
    clear      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ac_addr_d  = bus.req_addr;
          ac_snoop_d = bus.req_snoop;
          ac_prot_d  = bus.req_prot;
          resp_d     = '0;
          cr_got_d   = 1'b0;
          clear      = 1'b1;
          state_d    = ST_AC_SEND;
        end
      end
      ST_AC_SEND: if (bus.AC_READY) state_d = ST_RESP;
      ST_RESP: begin
        if (cr_fire) begin
          resp_d   = bus.CR_RESP;
          cr_got_d = 1'b1;
        end
        if (resp_exit) state_d = ST_DONE;
      end
      ST_DONE: if (bus.done_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ac_addr_q  <= '0;
      ac_snoop_q <= '0;
      ac_prot_q  <= '0;
      resp_q     <= '0;
      cr_got_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ac_addr_q  <= ac_addr_d;
      ac_snoop_q <= ac_snoop_d;
      ac_prot_q  <= ac_prot_d;
      resp_q     <= resp_d;
      cr_got_q   <= cr_got_d;
    end
  end

  ace_cd_line_collector #(
    .WIDTH_D    (WIDTH_D),
    .LINE_BEATS (LINE_BEATS)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .beat_fire (cd_fire),
    .cd_data   (bus.CD_DATA),
    .cd_last   (bus.CD_LAST),
    .cd_done   (cd_done),
    .any_beat  (any_beat),
    .err       (coll_err),
    .line      (line)
  );

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.AC_VALID        = (state_q == ST_AC_SEND);
  assign bus.AC_ADDR         = ac_addr_q;
  assign bus.AC_SNOOP        = ac_snoop_q;
  assign bus.AC_PROT         = ac_prot_q;
  assign bus.CR_READY        = cr_ready;
  assign bus.CD_READY        = cd_ready;
  assign bus.done_valid      = (state_q == ST_DONE);
  assign bus.done_resp       = resp_q;
  assign bus.done_data       = line;
  assign bus.done_data_valid = resp_q[CR_DATA_TRANSFER] && cd_done && !err;
  assign bus.done_err        = err;
endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Scenario bench for ace_snoop_initiator: expected completions are queued when a
// snoop is issued and compared against the completion record the DUT presents.
module tb_ace_snoop_initiator;
  import ace_pkg::*;

  localparam int WA = 32;
  localparam int WD = 32;
  localparam int LB = 4;

  typedef struct {
    logic [4:0]       resp;
    logic [WD*LB-1:0] data;
    logic             dv;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ace_snoop_initiator_if #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_BEATS(LB)) bus ();

  ace_snoop_initiator #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_BEATS(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    checks++;
    failures++;
    $display("FAIL timeout_%s: handshake never completed within budget", what);
  endtask

  task automatic send_req(input logic [WA-1:0] a, input logic [3:0] s, input logic [2:0] p);
    bus.req_addr = a; bus.req_snoop = s; bus.req_prot = p; bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
    if (!bus.req_ready) timeout("req"); else tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_ac();
    for (int i = 0; i < 50 && !bus.AC_VALID; i++) tick();
    if (!bus.AC_VALID) timeout("ac");
    bus.AC_READY = 1'b1;
    tick();
    bus.AC_READY = 1'b0;
  endtask

  task automatic send_cr(input logic [4:0] r);
    bus.CR_RESP = r; bus.CR_VALID = 1'b1;
    for (int i = 0; i < 50 && !bus.CR_READY; i++) tick();
    if (!bus.CR_READY) timeout("cr"); else tick();
    bus.CR_VALID = 1'b0;
  endtask

  task automatic send_cd(input logic [WD-1:0] d, input logic last);
    bus.CD_DATA = d; bus.CD_LAST = last; bus.CD_VALID = 1'b1;
    for (int i = 0; i < 50 && !bus.CD_READY; i++) tick();
    if (!bus.CD_READY) timeout("cd"); else tick();
    bus.CD_VALID = 1'b0; bus.CD_LAST = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !bus.done_valid; i++) tick();
    if (!bus.done_valid) timeout("done");
  endtask

  task automatic ack_done();
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_snoop = '0; bus.req_prot = '0;
    bus.AC_READY = 0; bus.CR_VALID = 0; bus.CR_RESP = '0;
    bus.CD_VALID = 0; bus.CD_DATA = '0; bus.CD_LAST = 0; bus.done_ready = 0;
    tick(); tick();
    checks++;
    if ({bus.AC_VALID, bus.CR_READY, bus.CD_READY, bus.done_valid, bus.done_data_valid, bus.done_err} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000",
        {bus.AC_VALID, bus.CR_READY, bus.CD_READY, bus.done_valid, bus.done_data_valid, bus.done_err});
    end
    checks++;
    if ({bus.AC_ADDR, bus.AC_SNOOP, bus.AC_PROT, bus.done_resp, bus.done_data} !== '0) begin
      failures++; $display("FAIL reset_data got_addr=%h got_resp=%h exp=0", bus.AC_ADDR, bus.done_resp);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_readshared();
    exp_t e;
    e.resp = 5'h09; e.data = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; e.dv = 1'b1; e.err = 1'b0;
    exp_q.push_back(e);
    send_req(32'h0000_1040, SNP_READ_SHARED, 3'b010);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.AC_VALID, bus.AC_ADDR, bus.AC_SNOOP, bus.AC_PROT} !== {1'b1, 32'h0000_1040, SNP_READ_SHARED, 3'b010}) begin
        failures++; $display("FAIL rs_ac_stall%0d got v=%b a=%h s=%h p=%h exp v=1 a=00001040 s=1 p=2",
          i, bus.AC_VALID, bus.AC_ADDR, bus.AC_SNOOP, bus.AC_PROT);
      end
      tick();
    end
    do_ac();
    checks++;
    if (bus.AC_VALID !== 1'b0) begin failures++; $display("FAIL rs_ac_drop got=%b exp=0", bus.AC_VALID); end
    send_cr(5'b01001);
    for (int b = 0; b < 4; b++) send_cd(32'hA0 + b, b == 3);
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_resp !== e.resp) begin failures++; $display("FAIL rs_resp got=%h exp=%h", bus.done_resp, e.resp); end
    checks++; if (bus.done_data !== e.data) begin failures++; $display("FAIL rs_data got=%h exp=%h", bus.done_data, e.data); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL rs_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL rs_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rs_idle got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_clean_invalid();
    exp_t e;
    e.resp = 5'h00; e.data = '0; e.dv = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    send_req(32'h0000_2000, SNP_CLEAN_INVALID, 3'b000);
    do_ac();
    send_cr(5'b00000);
    checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL ci_early got=%b exp=0", bus.done_valid); end
    tick();
    checks++; if (bus.done_valid !== 1'b1) begin failures++; $display("FAIL ci_latency got=%b exp=1", bus.done_valid); end
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_resp !== e.resp) begin failures++; $display("FAIL ci_resp got=%h exp=%h", bus.done_resp, e.resp); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL ci_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL ci_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
  endtask

  task automatic test_cd_before_cr();
    exp_t e;
    e.resp = 5'h05; e.data = {32'h13, 32'h12, 32'h11, 32'h10}; e.dv = 1'b1; e.err = 1'b0;
    exp_q.push_back(e);
    send_req(32'h0000_3000, SNP_READ_CLEAN, 3'b001);
    do_ac();
    for (int b = 0; b < 4; b++) send_cd(32'h10 + b, b == 3);
    checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL cdf_wait_cr got=%b exp=0", bus.done_valid); end
    send_cr(5'b00101);
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_resp !== e.resp) begin failures++; $display("FAIL cdf_resp got=%h exp=%h", bus.done_resp, e.resp); end
    checks++; if (bus.done_data !== e.data) begin failures++; $display("FAIL cdf_data got=%h exp=%h", bus.done_data, e.data); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL cdf_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    ack_done();
  endtask

  task automatic test_short_last();
    exp_t e;
    e.resp = 5'h01; e.data = {32'h0, 32'h0, 32'hB1, 32'hB0}; e.dv = 1'b0; e.err = 1'b1;
    exp_q.push_back(e);
    send_req(32'h0000_4000, SNP_READ_ONCE, 3'b000);
    do_ac();
    send_cr(5'b00001);
    send_cd(32'hB0, 1'b0);
    send_cd(32'hB1, 1'b1);
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_data !== e.data) begin failures++; $display("FAIL short_data got=%h exp=%h", bus.done_data, e.data); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL short_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL short_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
  endtask

  task automatic test_overflow();
    exp_t e;
    e.resp = 5'h01; e.data = {32'hC3, 32'hC2, 32'hC1, 32'hC0}; e.dv = 1'b0; e.err = 1'b1;
    exp_q.push_back(e);
    send_req(32'h0000_5000, SNP_READ_UNIQUE, 3'b000);
    do_ac();
    send_cr(5'b00001);
    for (int b = 0; b < 6; b++) send_cd(32'hC0 + b, b == 5);
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_data !== e.data) begin failures++; $display("FAIL ovf_data got=%h exp=%h", bus.done_data, e.data); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL ovf_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL ovf_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
  endtask

  task automatic test_data_no_dt();
    exp_t e;
    e.resp = 5'h00; e.data = '0; e.dv = 1'b0; e.err = 1'b1;
    exp_q.push_back(e);
    send_req(32'h0000_6000, SNP_CLEAN_SHARED, 3'b000);
    do_ac();
    send_cd(32'hE0, 1'b0);
    send_cr(5'b00000);
    tick();
    checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL nodt_drain got=%b exp=0", bus.done_valid); end
    send_cd(32'hE1, 1'b1);
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_resp !== e.resp) begin failures++; $display("FAIL nodt_resp got=%h exp=%h", bus.done_resp, e.resp); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL nodt_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL nodt_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
  endtask

  task automatic test_rst_mid_and_back_to_back();
    exp_t e;
    e.resp = 5'h01; e.data = '0; e.dv = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    send_req(32'h0000_7000, SNP_READ_SHARED, 3'b000);
    do_ac();
    send_cr(5'b00001);
    send_cd(32'hF0, 1'b0);
    send_cd(32'hF1, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if ({bus.AC_VALID, bus.CR_READY, bus.CD_READY, bus.done_valid, bus.done_data_valid, bus.done_err,
         bus.done_resp, bus.done_data} !== '0) begin
      failures++; $display("FAIL rst_async_outs got_resp=%h got_data=%h got_cd_rdy=%b exp=0",
        bus.done_resp, bus.done_data, bus.CD_READY);
    end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_async_idle got=%b exp=1", bus.req_ready); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_idle got=%b exp=1", bus.req_ready); end

    e.resp = 5'b10011; e.data = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; e.dv = 1'b1; e.err = 1'b0;
    exp_q.push_back(e);
    send_req(32'h0000_8040, SNP_READ_UNIQUE, 3'b011);
    do_ac();
    for (int b = 0; b < 3; b++) send_cd(32'hD0 + b, 1'b0);
    bus.CR_RESP = 5'b10011; bus.CR_VALID = 1'b1;
    bus.CD_DATA = 32'hD3; bus.CD_LAST = 1'b1; bus.CD_VALID = 1'b1;
    checks++; if ({bus.CR_READY, bus.CD_READY} !== 2'b11) begin failures++; $display("FAIL sim_ready got=%b exp=11", {bus.CR_READY, bus.CD_READY}); end
    tick();
    bus.CR_VALID = 1'b0; bus.CD_VALID = 1'b0; bus.CD_LAST = 1'b0;
    checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL sim_early got=%b exp=0", bus.done_valid); end
    tick();
    checks++; if (bus.done_valid !== 1'b1) begin failures++; $display("FAIL sim_latency got=%b exp=1", bus.done_valid); end
    wait_done();
    e = exp_q.pop_front();
    checks++; if (bus.done_resp !== e.resp) begin failures++; $display("FAIL sim_resp got=%h exp=%h", bus.done_resp, e.resp); end
    checks++; if (bus.done_data !== e.data) begin failures++; $display("FAIL sim_data got=%h exp=%h", bus.done_data, e.data); end
    checks++; if (bus.done_data_valid !== e.dv) begin failures++; $display("FAIL sim_dv got=%b exp=%b", bus.done_data_valid, e.dv); end
    checks++; if (bus.done_err !== e.err) begin failures++; $display("FAIL sim_err got=%b exp=%b", bus.done_err, e.err); end
    ack_done();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL sim_idle got=%b exp=1", bus.req_ready); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_readshared();
    test_clean_invalid();
    test_cd_before_cr();
    test_short_last();
    test_overflow();
    test_data_no_dt();
    test_rst_mid_and_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
